// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter.
package mux_rr_arbiter_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 8;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // LSB position of requester idx's word on the flattened In bus.
    function automatic int unsigned slice_lsb(input logic [IDX_W-1:0] idx,
                                              input int unsigned       w);
        return 32'(idx) * w;
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

    // First set request scanning circularly from ptr; the pointer position wins ties.
    function automatic pick_t pick_rr(input logic [N_REQ-1:0] req,
                                      input logic [IDX_W-1:0] ptr);
        pick_t            r;
        logic [IDX_W-1:0] idx;
        r.valid = 1'b0;
        r.idx   = '0;
        // Walk from the farthest offset down so the nearest hit is written last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) begin
                r.valid = 1'b1;
                r.idx   = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// DATA_W-wide 4:1 bus mux; output forced to zero when not enabled.
module mux_4to1_bus
    import mux_rr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [N_REQ*DATA_W-1:0] in_i,
    input  logic [IDX_W-1:0]        sel_i,
    input  logic                    en_i,
    output logic [DATA_W-1:0]       out_o
);

    // Select the addressed word, gated by the enable.
    always_comb begin
        out_o = '0;
        if (en_i) begin
            out_o = in_i[slice_lsb(sel_i, DATA_W) +: DATA_W];
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one DATA_W channel among four requesters
// by steering the select of a 4:1 datapath mux, with bounded bursts.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [N_REQ-1:0]        Req,
    input  logic [N_REQ*DATA_W-1:0] In,
    output logic [N_REQ-1:0]        Ack,
    output logic [DATA_W-1:0]       Out,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic [N_REQ-1:0]        Grant,
    output logic [IDX_W-1:0]        S,
    output logic                    Busy
);

    logic             state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] s_q,     s_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             busy_c;
    logic             valid_c;
    logic             xfer_c;
    logic             last_beat_c;
    logic             release_c;
    logic [IDX_W-1:0] ptr_rel_c;
    pick_t            pick_now_c;
    pick_t            pick_rel_c;

    assign busy_c      = (state_q == ST_GRANT);
    assign valid_c     = busy_c & Req[s_q];
    assign xfer_c      = valid_c & Out_Ready;
    assign last_beat_c = (cnt_q == CNT_W'(MAX_BURST - 1));
    // A withdrawn request releases immediately; otherwise the final beat of a burst does.
    assign release_c   = busy_c & ((xfer_c & last_beat_c) | ~Req[s_q]);
    assign ptr_rel_c   = s_q + IDX_W'(1);
    assign pick_now_c  = pick_rr(Req, ptr_q);
    assign pick_rel_c  = pick_rr(Req, ptr_rel_c);

    // State register: FSM state, grant/select, priority pointer and beat count.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            s_q     <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: arbitrate from IDLE, count beats and rotate on release.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_now_c.valid) begin
                    state_d = ST_GRANT;
                    s_d     = pick_now_c.idx;
                    grant_d = onehot4(pick_now_c.idx);
                end
            end
            ST_GRANT: begin
                if (release_c) begin
                    ptr_d = ptr_rel_c;
                    cnt_d = '0;
                    // Hand straight to the next winner so there is no idle bubble.
                    if (pick_rel_c.valid) begin
                        s_d     = pick_rel_c.idx;
                        grant_d = onehot4(pick_rel_c.idx);
                    end else begin
                        state_d = ST_IDLE;
                        s_d     = '0;
                        grant_d = '0;
                    end
                end else if (xfer_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                s_d     = '0;
            end
        endcase
    end

    // Output logic: handshake signals only exist while a grant is held.
    always_comb begin
        Out_Valid = 1'b0;
        Ack       = '0;
        if (busy_c) begin
            Out_Valid = valid_c;
            if (xfer_c) begin
                Ack = onehot4(s_q);
            end
        end
    end

    assign Grant = grant_q;
    assign S     = s_q;
    assign Busy  = busy_c;

    mux_4to1_bus #(
        .DATA_W (DATA_W)
    ) u_mux (
        .in_i  (In),
        .sel_i (s_q),
        .en_i  (busy_c),
        .out_o (Out)
    );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (DATA_W=8, MAX_BURST=4).
module tb_mux_rr_arbiter;

    logic        Clk;
    logic        Rst_n;
    logic [3:0]  Req;
    logic [31:0] In;
    logic [3:0]  Ack;
    logic [7:0]  Out;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [3:0]  Grant;
    logic [1:0]  S;
    logic        Busy;

    int n_tests;
    int n_fail;

    mux_rr_arbiter #(
        .DATA_W    (8),
        .MAX_BURST (4)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Req       (Req),
        .In        (In),
        .Ack       (Ack),
        .Out       (Out),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Grant     (Grant),
        .S         (S),
        .Busy      (Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs may then be changed for this cycle.
    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    // Pulse reset and release it between edges so the next edge arbitrates.
    task automatic apply_reset(input logic [3:0] req);
        Rst_n = 1'b0;
        Req   = req;
        @(posedge Clk);
        #2;
        Rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g;
        logic [7:0] exp_o;
        n_tests   = 0;
        n_fail    = 0;
        Rst_n     = 1'b0;
        Req       = 4'b1111;
        In        = 32'h0;
        Out_Ready = 1'b1;

        // 1. Reset state while all requesters are asking.
        repeat (3) @(posedge Clk);
        #3;
        chk("rst_grant", 32'(Grant), 32'h0);
        chk("rst_s", 32'(S), 32'h0);
        chk("rst_valid", 32'(Out_Valid), 32'h0);
        chk("rst_ack", 32'(Ack), 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_out", 32'(Out), 32'h0);
        Rst_n = 1'b1;
        step(); #1;
        chk("rst_rel_grant", 32'(Grant), 32'h1);
        chk("rst_rel_s", 32'(S), 32'h0);
        chk("rst_rel_busy", 32'(Busy), 32'h1);

        // 2. Lone requester 2: four beats, then re-granted with no bubble.
        In = 32'h00A5_0000;
        apply_reset(4'b0100);
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            chk("single_grant", 32'(Grant), 32'h4);
            chk("single_ack", 32'(Ack), 32'h4);
            chk("single_out", 32'(Out), 32'hA5);
        end
        chk("single_s", 32'(S), 32'h2);

        // 3. Full contention: 4 beats each to 0,1,2,3 then back to 0.
        In = 32'hC3C2_C1C0;
        apply_reset(4'b1111);
        for (int c = 0; c < 20; c++) begin
            step(); #1;
            exp_g = 4'b0001 << ((c / 4) % 4);
            exp_o = 8'hC0 + 8'((c / 4) % 4);
            chk("rr_grant", 32'(Grant), 32'(exp_g));
            chk("rr_ack", 32'(Ack), 32'(exp_g));
            chk("rr_valid", 32'(Out_Valid), 32'h1);
            chk("rr_out", 32'(Out), 32'(exp_o));
        end

        // 4. Backpressure in requester 1's burst after beat 2.
        In = 32'h3C00_5A00;
        Out_Ready = 1'b1;
        apply_reset(4'b1010);
        step(); #1;
        chk("bp_beat1", 32'(Ack), 32'h2);
        step(); #1;
        chk("bp_beat2", 32'(Ack), 32'h2);
        for (int i = 0; i < 3; i++) begin
            step();
            Out_Ready = 1'b0;
            #1;
            chk("bp_hold_ack", 32'(Ack), 32'h0);
            chk("bp_hold_s", 32'(S), 32'h1);
            chk("bp_hold_out", 32'(Out), 32'h5A);
            chk("bp_hold_valid", 32'(Out_Valid), 32'h1);
        end
        step();
        Out_Ready = 1'b1;
        #1;
        chk("bp_beat3", 32'(Ack), 32'h2);
        step(); #1;
        chk("bp_beat4", 32'(Ack), 32'h2);
        step(); #1;
        chk("bp_next_grant", 32'(Grant), 32'h8);
        chk("bp_next_s", 32'(S), 32'h3);
        chk("bp_next_out", 32'(Out), 32'h3C);

        // 5a. Requester 1 withdraws after 2 beats while 3 is waiting.
        apply_reset(4'b1010);
        step(); #1;
        chk("wd_beat1", 32'(Ack), 32'h2);
        step(); #1;
        chk("wd_beat2", 32'(Ack), 32'h2);
        step();
        Req = 4'b1000;
        #1;
        chk("wd_drop_valid", 32'(Out_Valid), 32'h0);
        chk("wd_drop_ack", 32'(Ack), 32'h0);
        step(); #1;
        chk("wd_grant3", 32'(Grant), 32'h8);
        chk("wd_s3", 32'(S), 32'h3);

        // 5b. Withdrawal with nobody else waiting returns to IDLE.
        apply_reset(4'b0010);
        step(); #1;
        chk("wd0_beat1", 32'(Ack), 32'h2);
        step();
        Req = 4'b0000;
        #1;
        chk("wd0_drop_ack", 32'(Ack), 32'h0);
        step(); #1;
        chk("wd0_busy", 32'(Busy), 32'h0);
        chk("wd0_grant", 32'(Grant), 32'h0);
        chk("wd0_valid", 32'(Out_Valid), 32'h0);
        chk("wd0_out", 32'(Out), 32'h0);

        // 6. Async reset during a burst after the pointer has moved to 3.
        In = 32'h00A5_0000;
        apply_reset(4'b0100);
        repeat (5) begin
            step();
        end
        #1;
        chk("ar_pre_ack", 32'(Ack), 32'h4);
        step(); #1;
        chk("ar_beat2_ack", 32'(Ack), 32'h4);
        Rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(Out_Valid), 32'h0);
        chk("ar_ack", 32'(Ack), 32'h0);
        chk("ar_grant", 32'(Grant), 32'h0);
        chk("ar_busy", 32'(Busy), 32'h0);
        chk("ar_out", 32'(Out), 32'h0);
        Req = 4'b1111;
        step();
        Rst_n = 1'b1;
        step(); #1;
        chk("ar_restart_grant", 32'(Grant), 32'h1);
        chk("ar_restart_s", 32'(S), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares one W-bit output channel between four requesters by sequencing the select of a 4:1 datapath mux. Each requester presents data with a request; the arbiter grants one at a time, forwards beats under a valid/ready handshake, and rotates priority after each burst. It sits in front of any single-consumer resource fed by the 4:1 mux family.

Parameters:
DATA_W, 8, width of each requester's data word and of Out
MAX_BURST, 4, maximum beats per grant before forced rotation (legal range 1..255)

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous, active-low reset
Req  input  4  per-requester request; bit i asserted while requester i has a beat on In
In  input  4*DATA_W  requester data; slice i = In[i*DATA_W +: DATA_W]
Ack  output  4  one-hot; Ack[i]=1 in the cycle requester i's beat is accepted
Out  output  DATA_W  selected data word
Out_Valid  output  1  beat present on Out
Out_Ready  input  1  consumer accepts the beat when high together with Out_Valid
Grant  output  4  one-hot registered grant, 0 when idle
S  output  2  registered mux select, the binary encoding of Grant
Busy  output  1  high in GRANT state

Behaviour:
- Interface: one clock (Clk); reset Rst_n is asynchronous, active-low.
- Reset values: state IDLE, Grant=0, S=0, Ptr=0, beat count=0. Outputs during reset: Out_Valid=0, Ack=0, Out=0, Busy=0.
- Reset asserted mid-burst: all outputs drop immediately, without waiting for a clock edge. The in-flight beat is not acknowledged.
- States: IDLE, GRANT.
- Pick function: the first set bit of Req, scanning circularly from Ptr (Ptr, Ptr+1, ... mod 4).
- IDLE:
  - If Req!=0 at edge N, register Grant/S = pick and enter GRANT. Grant is visible in cycle N+1 (1-cycle latency).
  - Else remain in IDLE.
- GRANT, combinational outputs:
  - Out = In slice S.
  - Out_Valid = Req[S].
  - Ack[S] = Out_Valid & Out_Ready; all other Ack bits are 0.
- GRANT, transfer and hold:
  - A transfer increments the beat count.
  - Out_Ready low: hold S and count. The requester must hold its In slice stable until Ack.
- Release: occurs at an edge when either:
  - a transfer occurs with count == MAX_BURST-1, or
  - Req[S]==0 (requester withdrew, no transfer that cycle).
- On release:
  - Ptr <= S+1 mod 4 and count <= 0.
  - If any Req bit is set, compute pick with the new pointer and register the next Grant directly, with no idle bubble. Otherwise go to IDLE.
  - The releasing requester can win again only if no other bit is set, because it is scanned last.
- Wrap-around: Ptr rolls from 3 to 0. The count never exceeds MAX_BURST-1.
- Req bits change only at clock edges. A Req rising on a non-granted port has no effect until the next arbitration.
- Outside GRANT: Out=0, Out_Valid=0, Ack=0.
- Grant is always one-hot or zero. S==log2(Grant) whenever Grant!=0.

Decomposition:
- Shared package holds:
  - state encoding localparams (ST_IDLE, ST_GRANT);
  - the slice-index helper for the In bus;
  - the circular-priority pick function (4-bit Req, 2-bit pointer, returning 2-bit index plus valid).
- One sub-module is natural: mux_4to1_bus, a DATA_W-wide 4:1 mux (In bus, S -> Out), instantiated once. Out is gated to 0 outside GRANT.

Test Plan:
1. Reset: hold Rst_n=0 with Req=4'b1111 -> Grant=0, S=0, Out_Valid=0, Ack=0. Release Rst_n -> one edge later Grant=4'b0001, S=0.
2. Single requester: Req=4'b0100, In slice2=8'hA5, Out_Ready=1 -> next cycle Grant=4'b0100, S=2, Out=8'hA5. Ack[2] is high 4 cycles, then the grant is released and re-issued to 2 with no bubble.
3. Full contention: Req=4'b1111 constant, Out_Ready=1, MAX_BURST=4 -> grants 0,1,2,3,0 with 4 beats each. Out_Valid stays high continuously, and exactly one Ack bit is set per cycle.
4. Backpressure: during requester 1's burst, Out_Ready=0 for 3 cycles after beat 2 -> S=1, Out, and count are held and Ack=0. The burst completes with beats 3-4 once Out_Ready=1.
5. Early withdrawal: requester 1 drops Req after 2 beats while Req[3]=1 -> next edge Grant=4'b1000 and Ptr=2. With Req=0 instead -> IDLE, Busy=0.
6. Async reset mid-burst: assert Rst_n=0 between edges during beat 2 -> Out_Valid, Ack, Grant, and Busy fall immediately. After release, arbitration restarts from Ptr=0.
